act_skew_feeder: RTL and testbench

//  Upstream feeder for the weight-stationary PE array: accepts one N-lane activation vector per cycle over valid/ready.

---
 rtl/act_skew_feeder.sv | 113 +++++++++++
 tb/tb_act_skew_feeder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_skew_feeder.sv
// Activation skew feeder for the weight-stationary PE array: lane i is delayed by i extra cycles, bubbles and drain rows are zero.
// Optional stall counter enabled by defining FEEDER_PERF_CNT_EN.
module act_skew_feeder #(
   parameter int N  = 4,
   parameter int DW = 16,
   parameter int LW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [LW-1:0]   tile_len,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] in_data,
   output logic [N*DW-1:0] out_act,
   output logic [N-1:0]    out_lv,
   output logic            busy,
   output logic            done,
   output logic [31:0]     stall_cnt
);

   // state  | meaning
   // IDLE   | waiting for start, skew line filled with zeros
   // STREAM | accepting vectors, zero bubble when input starves
   // DRAIN  | 2*N-1 zero cycles to flush partial sums out of the array
   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   localparam int DCW = $clog2(2*N-1);
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2*N-2);

   state_t         state, state_nx;
   logic [LW-1:0]  remaining;
   logic [DCW-1:0] drain_cnt;
   logic           hs;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = (tile_len != '0) ? STREAM : DRAIN;
         end
         STREAM: begin
            in_ready = 1'b1;
            if (in_valid && remaining == LW'(1)) state_nx = DRAIN;
         end
         DRAIN: begin
            if (drain_cnt == '0) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign hs   = in_valid & in_ready;
   assign busy = (state != IDLE);

   // Drain counter stays loaded outside DRAIN so it is ready the cycle DRAIN is entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         remaining <= '0;
         drain_cnt <= '0;
         done      <= 1'b0;
      end else begin
         done <= (state == DRAIN) && (drain_cnt == '0);
         if (state == IDLE && start) remaining <= tile_len;
         else if (hs)                remaining <= remaining - LW'(1);
         if (state != DRAIN)         drain_cnt <= DRAIN_LAST;
         else if (drain_cnt != '0)   drain_cnt <= drain_cnt - DCW'(1);
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DW-1:0] d_q [0:i];
      logic [i:0]    v_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int s = 0; s <= i; s++) d_q[s] <= '0;
            v_q <= '0;
         end else begin
            d_q[0] <= hs ? in_data[i*DW +: DW] : '0;
            v_q[0] <= hs;
            for (int s = 1; s <= i; s++) begin
               d_q[s] <= d_q[s-1];
               v_q[s] <= v_q[s-1];
            end
         end
      end

      assign out_act[i*DW +: DW] = d_q[i];
      assign out_lv[i]           = v_q[i];
   end

`ifdef FEEDER_PERF_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst)                                                  stall_q <= '0;
      else if (state == IDLE && start)                          stall_q <= '0;
      else if (state == STREAM && !in_valid && stall_q != '1)   stall_q <= stall_q + 32'd1;
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_act_skew_feeder.sv
// Self-checking bench for act_skew_feeder: per-lane scoreboard of skewed activations plus per-scenario timing checks.
module tb_act_skew_feeder;
   localparam int N  = 4;
   localparam int DW = 16;
   localparam int LW = 16;

`ifdef FEEDER_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [LW-1:0]   tile_len = '0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [N*DW-1:0] in_data = '0;
   logic [N*DW-1:0] out_act;
   logic [N-1:0]    out_lv;
   logic            busy;
   logic            done;
   logic [31:0]     stall_cnt;

   act_skew_feeder #(.N(N), .DW(DW), .LW(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .tile_len(tile_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_act(out_act), .out_lv(out_lv), .busy(busy), .done(done),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      int            due;
      logic [DW-1:0] d;
   } ent_t;

   ent_t sb [N][$];
   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;

   ent_t          mon_e;
   logic [DW-1:0] mon_lane;

   // Output scoreboard: every real lane value must match the expected data on its due cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < N; i++) begin
            mon_lane = out_act[i*DW +: DW];
            checks++;
            if (out_lv[i] === 1'b1) begin
               if (sb[i].size() == 0) begin
                  errors++;
                  $display("FAIL lane%0d_unexpected: lv=1 act=%h at cyc %0d, required no data", i, mon_lane, cyc);
               end else begin
                  mon_e = sb[i].pop_front();
                  if (mon_lane !== mon_e.d || cyc != mon_e.due) begin
                     errors++;
                     $display("FAIL lane%0d_data: act=%h at cyc %0d, required %h at cyc %0d",
                              i, mon_lane, cyc, mon_e.d, mon_e.due);
                  end
               end
            end else if (out_lv[i] !== 1'b0 || mon_lane !== '0) begin
               errors++;
               $display("FAIL lane%0d_bubble: lv=%b act=%h at cyc %0d, required lv=0 act=0", i, out_lv[i], mon_lane, cyc);
            end
         end
      end
   end

   function automatic logic [N*DW-1:0] rand_vec();
      logic [N*DW-1:0] v;
      for (int i = 0; i < N; i++) v[i*DW +: DW] = 16'($urandom_range(1, 65535));
      return v;
   endfunction

   task automatic push_vec(input logic [N*DW-1:0] v, input int c);
      ent_t e;
      for (int i = 0; i < N; i++) begin
         e.due = c + 1 + i;
         e.d   = v[i*DW +: DW];
         sb[i].push_back(e);
      end
   endtask

   // Runs one tile; gap_len starved cycles are inserted after gap_after vectors. Returns observed timing.
   task automatic run_tile(input int len, input int gap_after, input int gap_len,
                           input logic [N*DW-1:0] first_vec,
                           output int start_c, output int done_c, output logic [63:0] rdy_tr);
      int   sent, gaps, idx;
      logic v;
      sent = 0; gaps = 0; done_c = -1; rdy_tr = '0;
      @(posedge clk); #1;
      start = 1'b1; tile_len = LW'(len); in_valid = 1'b0; start_c = cyc;
      @(negedge clk);
      idx = cyc - start_c; if (idx >= 0 && idx < 64) rdy_tr[idx] = in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 200 && sent < len; k++) begin
         v = !(sent == gap_after && gaps < gap_len);
         in_valid = v;
         in_data  = (sent == 0 && first_vec != '0) ? first_vec : rand_vec();
         if (v) push_vec(in_data, cyc);
         @(negedge clk);
         idx = cyc - start_c; if (idx >= 0 && idx < 64) rdy_tr[idx] = in_ready;
         @(posedge clk); #1;
         if (v) sent++; else gaps++;
      end
      in_valid = 1'b1;
      in_data  = rand_vec();
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         idx = cyc - start_c; if (idx >= 0 && idx < 64) rdy_tr[idx] = in_ready;
         if (done === 1'b1) begin done_c = cyc; break; end
         @(posedge clk); #1;
         in_data = rand_vec();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0; mon_en = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_act !== '0 || out_lv !== '0 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || stall_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_idle: act=%h lv=%b rdy=%b busy=%b done=%b stall=%0d, required all zero",
                  out_act, out_lv, in_ready, busy, done, stall_cnt);
      end
   endtask

   task automatic test_single();
      int s, d; logic [63:0] r;
      run_tile(1, -1, 0, {16'd4, 16'd3, 16'd2, 16'd1}, s, d, r);
      checks++;
      if (d != s + 9) begin errors++; $display("FAIL single_done: done at +%0d, required +9", d - s); end
      checks++;
      if (r !== 64'b10) begin errors++; $display("FAIL single_ready: trace=%b, required %b", r, 64'b10); end
      @(posedge clk); #1; @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL single_pulse: done=%b busy=%b, required 0 0", done, busy);
      end
   endtask

   task automatic test_stream3();
      int s, d; logic [63:0] r;
      run_tile(3, -1, 0, '0, s, d, r);
      checks++;
      if (d != s + 11) begin errors++; $display("FAIL stream3_done: done at +%0d, required +11", d - s); end
      checks++;
      if (r !== 64'b1110) begin errors++; $display("FAIL stream3_ready: trace=%b, required %b", r, 64'b1110); end
   endtask

   task automatic test_gaps();
      int s, d; logic [63:0] r; logic [31:0] exp_stall;
      exp_stall = PERF ? 32'd2 : 32'd0;
      run_tile(2, 1, 2, '0, s, d, r);
      checks++;
      if (d != s + 12) begin errors++; $display("FAIL gaps_done: done at +%0d, required +12", d - s); end
      checks++;
      if (r !== 64'b11110) begin errors++; $display("FAIL gaps_ready: trace=%b, required %b", r, 64'b11110); end
      checks++;
      if (stall_cnt !== exp_stall) begin
         errors++; $display("FAIL gaps_stall: stall_cnt=%0d, required %0d", stall_cnt, exp_stall);
      end
   endtask

   task automatic test_zero_len();
      int s, d;
      d = -1;
      @(posedge clk); #1;
      start = 1'b1; tile_len = '0; s = cyc;
      for (int k = 1; k < 40; k++) begin
         @(posedge clk); #1;
         start    = (k == 3);
         tile_len = (k == 3) ? LW'(5) : '0;
         in_valid = (k == 3);
         in_data  = rand_vec();
         @(negedge clk);
         if (k == 1) begin
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
               errors++; $display("FAIL zero_drain: busy=%b rdy=%b, required 1 0", busy, in_ready);
            end
         end
         if (done === 1'b1) begin d = cyc; break; end
      end
      start = 1'b0; in_valid = 1'b0;
      checks++;
      if (d != s + 8) begin errors++; $display("FAIL zero_done: done at +%0d, required +8", d - s); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL zero_start_ignored: busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_back_to_back();
      int s1, d1, s2, d2; logic [63:0] r1, r2;
      run_tile(2, -1, 0, '0, s1, d1, r1);
      run_tile(4, -1, 0, '0, s2, d2, r2);
      checks++;
      if (d1 != s1 + 10 || d2 != s2 + 12) begin
         errors++; $display("FAIL b2b_done: done at +%0d/+%0d, required +10/+12", d1 - s1, d2 - s2);
      end
      checks++;
      if (r2 !== 64'b11110) begin errors++; $display("FAIL b2b_ready: trace=%b, required %b", r2, 64'b11110); end
      checks++;
      if (stall_cnt !== 32'd0) begin errors++; $display("FAIL b2b_stall: stall_cnt=%0d, required 0", stall_cnt); end
   endtask

   task automatic test_reset_mid();
      ent_t e; int ndone;
      @(posedge clk); #1;
      start = 1'b1; tile_len = LW'(3);
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; in_data = rand_vec();
      e.due = cyc + 1; e.d = in_data[DW-1:0];
      sb[0].push_back(e);
      @(posedge clk); #1;
      rst = 1'b1; in_data = rand_vec();
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_act !== '0 || out_lv !== '0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || stall_cnt !== 32'd0) begin
         errors++;
         $display("FAIL rst_mid_outputs: act=%h lv=%b busy=%b rdy=%b done=%b stall=%0d, required all zero",
                  out_act, out_lv, busy, in_ready, done, stall_cnt);
      end
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 0) begin errors++; $display("FAIL rst_mid_no_done: %0d done pulses, required 0", ndone); end
   endtask

   task automatic test_end();
      for (int i = 0; i < N; i++) begin
         checks++;
         if (sb[i].size() != 0) begin
            errors++; $display("FAIL lane%0d_missing: %0d expected values never seen, required 0", i, sb[i].size());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream3();
      test_gaps();
      test_zero_len();
      test_back_to_back();
      test_reset_mid();
      test_end();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
